// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing generator on the pixel clock.
// Ports: clk, reset (async, active-high), ena (count enable);
//   x_px/y_px (10-bit position), hsync/vsync (level per SYNC_POL),
//   activevideo, line_start, frame_start, frame_cnt (16-bit, wraps).
// All outputs are flops loaded from the same next-position value,
// so the decoded flags never lag the counters they describe.
// H_TOTAL and V_TOTAL must each be at most 1024 (10-bit counters).
module vga_sync_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ena,
   output logic [9:0]  x_px,
   output logic [9:0]  y_px,
   output logic        hsync,
   output logic        vsync,
   output logic        activevideo,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 11-bit constants so a total of exactly 1024 is still representable.
   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS   = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [15:0] fc_q, fc_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        av_q, av_d;
   logic        ls_q, ls_d;
   logic        fs_q, fs_d;
   logic [10:0] xw, yw;

   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      fc_d = fc_q;
      if (ena) begin
         if ({1'b0, x_q} == H_LAST) begin
            x_d = '0;
            if ({1'b0, y_q} == V_LAST) begin
               y_d  = '0;
               fc_d = fc_q + 16'd1;
            end else begin
               y_d = y_q + 10'd1;
            end
         end else begin
            x_d = x_q + 10'd1;
         end
      end

      // Flags decode the next position; with ena low that is the
      // current position, so every output holds without extra gating.
      xw   = {1'b0, x_d};
      yw   = {1'b0, y_d};
      hs_d = (xw >= HS_BEG && xw < HS_END) ? SYNC_POL : ~SYNC_POL;
      vs_d = (yw >= VS_BEG && yw < VS_END) ? SYNC_POL : ~SYNC_POL;
      av_d = (xw < H_VIS) && (yw < V_VIS);
      ls_d = (x_d == 10'd0);
      fs_d = (x_d == 10'd0) && (y_d == 10'd0);
   end

   // Reset state is the decode of position (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q  <= '0;
         y_q  <= '0;
         fc_q <= '0;
         hs_q <= ~SYNC_POL;
         vs_q <= ~SYNC_POL;
         av_q <= 1'b1;
         ls_q <= 1'b1;
         fs_q <= 1'b1;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         fc_q <= fc_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         av_q <= av_d;
         ls_q <= ls_d;
         fs_q <= fs_d;
      end
   end

   assign x_px        = x_q;
   assign y_px        = y_q;
   assign frame_cnt   = fc_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign activevideo = av_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen (640x480 and a tiny raster)
// against a position model derived from the enabled-edge count.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic reset;
   logic ena;

   always #5 clk = ~clk;

   logic [9:0]  xa, ya, xb, yb;
   logic [15:0] fca, fcb;
   logic hsa, vsa, ava, lsa, fsa;
   logic hsb, vsb, avb, lsb, fsb;

   vga_sync_gen dut_a (
      .clk(clk), .reset(reset), .ena(ena),
      .x_px(xa), .y_px(ya), .hsync(hsa), .vsync(vsa),
      .activevideo(ava), .line_start(lsa), .frame_start(fsa),
      .frame_cnt(fca)
   );

   // Tiny raster: 16 clocks/line, 8 lines/frame, active-high sync.
   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .ena(ena),
      .x_px(xb), .y_px(yb), .hsync(hsb), .vsync(vsb),
      .activevideo(avb), .line_start(lsb), .frame_start(fsb),
      .frame_cnt(fcb)
   );

   int errors = 0;
   int checks = 0;
   longint na = 0;
   longint nb = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Expected output vector after n enabled edges since reset:
   // {frame_cnt, y, x, hsync, vsync, activevideo, line_start, frame_start}
   function automatic logic [40:0] model(
      input longint n, input int ha, input int hf, input int hs,
      input int hb, input int va, input int vf, input int vs,
      input int vb, input logic pol);
      longint ht, vt, x, y, f;
      logic h, v, a, l, s;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      x  = n % ht;
      y  = (n / ht) % vt;
      f  = (n / (ht * vt)) % 65536;
      h  = (x >= ha + hf && x < ha + hf + hs) ? pol : ~pol;
      v  = (y >= va + vf && y < va + vf + vs) ? pol : ~pol;
      a  = (x < ha) && (y < va);
      l  = (x == 0);
      s  = (x == 0) && (y == 0);
      return {16'(f), 10'(y), 10'(x), h, v, a, l, s};
   endfunction

   function automatic logic [40:0] exp_a(input longint n);
      return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic logic [40:0] exp_b(input longint n);
      return model(n, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1);
   endfunction

   function automatic logic [40:0] act_a();
      return {fca, ya, xa, hsa, vsa, ava, lsa, fsa};
   endfunction

   function automatic logic [40:0] act_b();
      return {fcb, yb, xb, hsb, vsb, avb, lsb, fsb};
   endfunction

   // Model advance plus per-cycle comparison, sampled 1 time unit
   // after the rising edge; literal pins tie the model to known values.
   always @(posedge clk) begin
      if (reset) begin
         na = 0;
         nb = 0;
      end else if (ena) begin
         na++;
         nb++;
      end
      #1;
      chk("dut_a_cycle", 64'(act_a()), 64'(exp_a(na)));
      chk("dut_b_cycle", 64'(act_b()), 64'(exp_b(nb)));
      case (na)
         1: chk("a_first_edge", {xa, lsa, fsa}, {10'd1, 1'b0, 1'b0});
         639: chk("a_x639", {xa, ava}, {10'd639, 1'b1});
         640: chk("a_x640", {xa, ava}, {10'd640, 1'b0});
         655: chk("a_hs655", hsa, 1'b1);
         656: chk("a_hs656", hsa, 1'b0);
         751: chk("a_hs751", hsa, 1'b0);
         752: chk("a_hs752", hsa, 1'b1);
         800: chk("a_line1", {xa, ya, lsa, fsa},
                  {10'd0, 10'd1, 1'b1, 1'b0});
         default: ;
      endcase
      case (nb)
         79:  chk("b_vs_y4", vsb, 1'b0);
         80:  chk("b_vs_y5", vsb, 1'b1);
         111: chk("b_vs_y6", vsb, 1'b1);
         112: chk("b_vs_y7", vsb, 1'b0);
         128: chk("b_wrap1", {xb, yb, fcb, fsb, avb},
                  {10'd0, 10'd0, 16'd1, 1'b1, 1'b1});
         256: chk("b_wrap2", {fcb, fsb}, {16'd2, 1'b1});
         default: ;
      endcase
   end

   initial begin
      int guard;
      reset = 1'b1;
      ena   = 1'b0;
      #3;
      chk("a_reset_pre_edge", 64'(act_a()), 64'(exp_a(0)));
      chk("b_reset_pre_edge", 64'(act_b()), 64'(exp_b(0)));
      chk("a_reset_literal", 64'(act_a()),
          64'({16'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      ena   = 1'b1;

      // Run at full enable up to position (100,5) of the 640x480 raster.
      guard = 0;
      while (na < 4100 && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      chk("a_reach_4100", 64'(na), 64'd4100);
      ena = 1'b0;
      repeat (50) @(negedge clk);
      chk("a_hold_pos", {xa, ya}, {10'd100, 10'd5});
      ena = 1'b1;
      @(negedge clk);
      chk("a_resume", {xa, ya}, {10'd101, 10'd5});

      // Random enable pattern.
      repeat (1500) begin
         @(negedge clk);
         ena = ($urandom_range(0, 3) != 0);
      end

      // Asynchronous reset between edges: outputs must clear at once.
      reset = 1'b1;
      #1;
      chk("a_async_reset", 64'(act_a()), 64'(exp_a(0)));
      chk("b_async_reset", 64'(act_b()), 64'(exp_b(0)));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ena   = 1'b1;
      repeat (300) begin
         @(negedge clk);
         ena = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator for the 640x480@60 Hz display path, clocked from the 25 MHz pixel clock. It sits directly upstream of the pixel/shader stage in `tt_um_vga_example`. It produces the sync pulses, active-video flag, pixel coordinates and frame counter that the shader consumes and that the top level packs into `uo_out`. All outputs are registered and mutually aligned.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks); H_TOTAL = 800
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines); V_TOTAL = 525
- `SYNC_POL`, 0, sync asserted level (0 = active-low, as 640x480 requires)

Ports:
- `clk`  in  1  pixel clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `ena`  in  1  count enable; when 0, all registers hold
- `x_px`  out  10  horizontal counter, 0..H_TOTAL-1
- `y_px`  out  10  vertical counter, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, level per SYNC_POL
- `vsync`  out  1  vertical sync, level per SYNC_POL
- `activevideo`  out  1  1 when x_px < H_ACTIVE and y_px < V_ACTIVE
- `line_start`  out  1  1 when x_px == 0
- `frame_start`  out  1  1 when x_px == 0 and y_px == 0
- `frame_cnt`  out  16  completed-frame counter

## Operation
- Each enabled clock advances `x_px` by 1.
- When `x_px` == H_TOTAL-1, the next value of `x_px` is 0 and `y_px` advances by 1.
- When `y_px` == V_TOTAL-1 at the same point, `y_px` goes to 0 and `frame_cnt` increments, wrapping from 65535 to 0.
- Every other output is a registered decode of the next counter value. On every cycle, each output describes exactly the (`x_px`, `y_px`) it accompanies, with no skew between them.
- `hsync` is asserted (== SYNC_POL) for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751]. It is deasserted otherwise.
- `vsync` is asserted for whole lines y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491]. It changes only when x goes 799 -> 0.
- `ena` = 0 freezes counters and all outputs (no strobe repeats or clears). Resuming continues from the held position.
- Width rules:
  - Counters are 10-bit unsigned.
  - Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024.
  - Comparisons use widened constants; no truncation.

## Timing
- Reset values (asynchronous, held while `reset` = 1) are the decode of position (0,0): x_px=0, y_px=0, frame_cnt=0, activevideo=1, line_start=1, frame_start=1, hsync=~SYNC_POL, vsync=~SYNC_POL.
- First enabled edge after `reset` falls: x_px=1, line_start=0, frame_start=0.
- Latency is zero between the counter and its decoded flags, because both are registered from the same next-state value.
- hsync asserts on the edge where x becomes 656 and deasserts on the edge where x becomes 752.
- One line is 800 clocks; one frame is 420000 clocks.
- Simultaneous wrap (x=799, y=524, ena=1) produces all of the following on one edge:
  - x=0, y=0
  - frame_cnt+1
  - frame_start=1, line_start=1, activevideo=1
  - vsync deasserted
- Reset asserted mid-frame returns all outputs to their reset values immediately, without waiting for a clock. Counting restarts from (0,0) on release.
- No combinational path exists from any input to any output other than through `reset`.

## Test plan
- Reset and first line: hold `reset`, then release.
  - Required: outputs equal the reset values before any edge.
  - After 1 edge: x=1.
  - After 639 edges: x=639, activevideo=1.
  - After 640 edges: x=640, activevideo=0.
- hsync window: from reset, count edges.
  - Required: hsync=1 at x=655, hsync=0 at x=656 through x=751, hsync=1 at x=752.
  - Required: after 800 edges, x=0, y=1, line_start=1, frame_start=0.
- Vertical blanking and vsync: run 480*800 edges.
  - Required: y=480, activevideo=0.
  - Required: vsync=0 exactly for y=490 and y=491 (1600 clocks total) and 1 elsewhere.
- Frame wrap: run 420000 edges from reset.
  - Required: x=0, y=0, frame_cnt=1, frame_start=1.
  - Required: after 2*420000 edges, frame_cnt=2.
- Enable hold: at x=100, y=5, drive `ena`=0 for 50 clocks.
  - Required: all outputs unchanged throughout.
  - Required: the first edge after `ena`=1 gives x=101.
- Async reset mid-frame and frame_cnt wrap:
  - Assert `reset` between edges at y=300. Required: outputs return to reset values before the next edge.
  - Force frame_cnt=65535 at x=799, y=524, then apply one edge. Required: frame_cnt=0.
